// File: rtl/debug_pkg.sv
// Shared constants for the debug dump path: FSM encodings and byte-lane sizing.
package debug_pkg;

   localparam int DEFAULT_NB_DATA = 32;
   localparam int NB_BYTE         = 8;
   localparam int BYTES_PER_WORD  = DEFAULT_NB_DATA / NB_BYTE;
   localparam int NB_BYTE_CNT     = $clog2(BYTES_PER_WORD);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // A one-byte word still needs a 1-bit counter to keep the ports legal.
   function automatic int byte_cnt_width(input int bytes_per_word);
      return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
   endfunction

endpackage

// File: rtl/word_to_byte_serializer.sv
// Loads one memory word and emits it MSB byte first on a valid/ready stream.
module word_to_byte_serializer #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_clear,
   input  logic               i_load,
   input  logic [NB_DATA-1:0] i_word,
   input  logic               i_tx_ready,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   output logic               o_handshake,
   output logic               o_last_byte
);
   import debug_pkg::*;

   localparam int WORD_BYTES = NB_DATA / NB_BYTE;
   localparam int CNT_W      = byte_cnt_width(WORD_BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BYTES - 1);

   logic [NB_DATA-1:0] word_reg;
   logic [CNT_W-1:0]   byte_cnt;
   logic               sending;

   assign o_tx_valid  = sending;
   assign o_handshake = sending & i_tx_ready;
   assign o_last_byte = (byte_cnt == LAST_IDX);
   // The outgoing byte is always the top lane; the register shifts left on each accepted byte.
   assign o_tx_data   = sending ? word_reg[NB_DATA-1 -: NB_BYTE] : '0;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         word_reg <= '0;
         byte_cnt <= '0;
         sending  <= 1'b0;
      end else if (i_clear) begin
         byte_cnt <= '0;
         sending  <= 1'b0;
      end else if (i_load) begin
         word_reg <= i_word;
         byte_cnt <= '0;
         sending  <= 1'b1;
      end else if (o_handshake) begin
         if (o_last_byte) begin
            sending <= 1'b0;
         end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            word_reg <= word_reg << NB_BYTE;
         end
      end
   end

endmodule

// File: rtl/data_memory_dumper.sv
// Walks the whole data memory while the pipeline is halted and streams every word out byte by byte.
module data_memory_dumper #(
   parameter int NB_ADDR   = 5,
   parameter int NB_DATA   = 32,
   parameter int NB_BYTE   = 8,
   parameter int RAM_DEPTH = 2**NB_ADDR
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_mem_read_enable,
   output logic [NB_ADDR-1:0] o_mem_read_address,
   input  logic [NB_DATA-1:0] i_mem_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready
);
   import debug_pkg::*;

   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

   logic [1:0]         state;
   logic [1:0]         state_next;
   logic [NB_ADDR-1:0] addr_cnt;
   logic               handshake;
   logic               last_byte;
   logic               word_sent;

   word_to_byte_serializer #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_serializer (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_clear     (state == ST_IDLE),
      .i_load      (state == ST_READ),
      .i_word      (i_mem_data),
      .i_tx_ready  (i_tx_ready),
      .o_tx_data   (o_tx_data),
      .o_tx_valid  (o_tx_valid),
      .o_handshake (handshake),
      .o_last_byte (last_byte)
   );

   assign word_sent = (state == ST_SEND) & handshake & last_byte;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (i_start) state_next = ST_READ;
         ST_READ: state_next = ST_SEND;
         ST_SEND: if (word_sent) state_next = (addr_cnt == LAST_ADDR) ? ST_DONE : ST_READ;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Termination is the compare against LAST_ADDR, so the counter never wraps back to 0.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= ST_IDLE;
         addr_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE) begin
            addr_cnt <= '0;
         end else if (word_sent && (addr_cnt != LAST_ADDR)) begin
            addr_cnt <= addr_cnt + NB_ADDR'(1);
         end
      end
   end

   assign o_busy             = (state != ST_IDLE);
   assign o_done             = (state == ST_DONE);
   assign o_mem_read_enable  = (state == ST_READ);
   assign o_mem_read_address = addr_cnt;

endmodule

// File: tb/tb_data_memory_dumper.sv
// Bench for data_memory_dumper: a stream-level scoreboard plus directed scenarios.
module tb_data_memory_dumper;

   localparam int DEPTH = 32;
   localparam int BPW   = 4;
   localparam int TOTAL = DEPTH * BPW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT A: 32-word memory
   logic        a_start = 1'b0;
   logic        a_busy, a_done, a_rd_en, a_valid;
   logic [4:0]  a_addr;
   logic [31:0] a_mem_data;
   logic [7:0]  a_data;
   logic        a_ready;
   logic        ready_fix = 1'b1;
   logic        rnd_mode = 1'b0;
   logic        rnd_bit = 1'b0;
   logic [31:0] mem_a [DEPTH];

   assign a_ready    = rnd_mode ? rnd_bit : ready_fix;
   assign a_mem_data = a_rd_en ? mem_a[a_addr] : 32'h0;

   data_memory_dumper dut_a (
      .i_clock            (clk),
      .i_reset_n          (rst_n),
      .i_start            (a_start),
      .o_busy             (a_busy),
      .o_done             (a_done),
      .o_mem_read_enable  (a_rd_en),
      .o_mem_read_address (a_addr),
      .i_mem_data         (a_mem_data),
      .o_tx_data          (a_data),
      .o_tx_valid         (a_valid),
      .i_tx_ready         (a_ready)
   );

   // DUT B: 4-word memory
   logic        b_start = 1'b0;
   logic        b_busy, b_done, b_rd_en, b_valid;
   logic [1:0]  b_addr;
   logic [31:0] b_mem_data;
   logic [7:0]  b_data;
   logic        b_ready = 1'b1;
   logic [31:0] mem_b [4];

   assign b_mem_data = b_rd_en ? mem_b[b_addr] : 32'h0;

   data_memory_dumper #(.NB_ADDR(2)) dut_b (
      .i_clock            (clk),
      .i_reset_n          (rst_n),
      .i_start            (b_start),
      .o_busy             (b_busy),
      .o_done             (b_done),
      .o_mem_read_enable  (b_rd_en),
      .o_mem_read_address (b_addr),
      .i_mem_data         (b_mem_data),
      .o_tx_data          (b_data),
      .o_tx_valid         (b_valid),
      .i_tx_ready         (b_ready)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   initial forever begin
      @(posedge clk);
      #2;
      rnd_bit = ($urandom_range(0, 9) < 3);
   end

   // Scoreboard state: stream position and expected control outputs for the current cycle
   int          idx = 0;
   logic        exp_busy = 1'b0, exp_read = 1'b0, exp_done = 1'b0;
   logic        prev_valid = 1'b0, prev_ready = 1'b0;
   logic [7:0]  prev_data = 8'h0;
   int          done_cnt = 0, done_cyc = 0, rd_cnt = 0;
   logic [4:0]  first_rd_addr = 5'h0;
   logic [7:0]  got [$];

   function automatic logic [7:0] exp_byte(input int i);
      logic [31:0] w;
      w = mem_a[(i / BPW) % DEPTH];
      return 8'((w >> (8 * (BPW - 1 - (i % BPW)))) & 32'hFF);
   endfunction

   initial forever begin
      logic exp_valid, hs, accept, last_hs, last_word;
      @(negedge clk);
      if (!rst_n) begin
         check("rst_busy", a_busy, 0);
         check("rst_done", a_done, 0);
         check("rst_rd_en", a_rd_en, 0);
         check("rst_addr", a_addr, 0);
         check("rst_tx_data", a_data, 0);
         check("rst_tx_valid", a_valid, 0);
         idx = 0; exp_busy = 0; exp_read = 0; exp_done = 0; prev_valid = 0; prev_ready = 0;
      end else begin
         exp_valid = exp_busy && !exp_read && !exp_done;
         check("busy", a_busy, exp_busy);
         check("done", a_done, exp_done);
         check("rd_en", a_rd_en, exp_read);
         check("tx_valid", a_valid, exp_valid);
         if (exp_read) begin
            check("rd_addr", a_addr, 32'((idx / BPW) % DEPTH));
            if (rd_cnt == 0) first_rd_addr = a_addr;
            rd_cnt++;
         end
         if (exp_valid) check("tx_data", a_data, exp_byte(idx));
         else           check("tx_data_idle", a_data, 0);
         if (prev_valid && !prev_ready) begin
            check("stall_valid", a_valid, 1);
            check("stall_data", a_data, prev_data);
         end
         if (a_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         hs        = exp_valid && a_ready;
         accept    = !exp_busy && a_start;
         last_hs   = hs && ((idx % BPW) == BPW - 1);
         last_word = ((idx / BPW) % DEPTH) == DEPTH - 1;
         if (hs) got.push_back(a_data);
         prev_valid = a_valid;
         prev_ready = a_ready;
         prev_data  = a_data;
         exp_busy   = accept || (exp_busy && !exp_done);
         exp_done   = last_hs && last_word;
         exp_read   = accept || (last_hs && !last_word);
         if (hs) idx++;
      end
   end

   // DUT B observation
   logic [7:0] got_b [$];
   int         done_b = 0, rd_b = 0, max_b = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (b_valid && b_ready) got_b.push_back(b_data);
         if (b_done) done_b++;
         if (b_rd_en) rd_b++;
         if (int'(b_addr) > max_b) max_b = int'(b_addr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input int d0, input int bound);
      int n = 0;
      while (done_cnt == d0 && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("done_timeout", done_cnt != d0, 1);
   endtask

   task automatic run_dump(input int bound, output int lat, output int n_done);
      int d0;
      d0 = done_cnt;
      got.delete();
      rd_cnt = 0;
      tick();
      a_start = 1'b1;
      lat = cyc;
      tick();
      a_start = 1'b0;
      wait_done(d0, bound);
      lat = done_cyc - lat;
      repeat (4) tick();
      n_done = done_cnt - d0;
   endtask

   logic [7:0] ref_stream [$];
   logic [7:0] exp_b [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                             8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};

   initial begin
      int lat, nd, d0, n;
      for (int a = 0; a < DEPTH; a++) mem_a[a] = 32'hA5A50000 | 32'(a);
      mem_b[0] = 32'h11223344; mem_b[1] = 32'h55667788;
      mem_b[2] = 32'h99AABBCC; mem_b[3] = 32'hDDEEFF00;

      #1;
      check("init_busy", a_busy, 0);
      check("init_valid", a_valid, 0);
      check("init_tx_data", a_data, 0);
      repeat (2) tick();
      rst_n = 1'b1;

      // Plain dump with ready held high
      run_dump(2000, lat, nd);
      check("s1_latency", lat, 161);
      check("s1_done_count", nd, 1);
      check("s1_read_cycles", rd_cnt, 32);
      check("s1_bytes", got.size(), TOTAL);
      if (got.size() == TOTAL) begin
         check("s1_b0", got[0], 8'hA5);
         check("s1_b1", got[1], 8'hA5);
         check("s1_b2", got[2], 8'h00);
         check("s1_b3", got[3], 8'h00);
         check("s1_b124", got[124], 8'hA5);
         check("s1_b125", got[125], 8'hA5);
         check("s1_b126", got[126], 8'h00);
         check("s1_b127", got[127], 8'h1F);
      end
      ref_stream = got;

      // Random backpressure
      rnd_mode = 1'b1;
      run_dump(5000, lat, nd);
      rnd_mode = 1'b0;
      check("s2_done_count", nd, 1);
      check("s2_bytes", got.size(), TOTAL);
      if (got.size() == TOTAL)
         for (int i = 0; i < TOTAL; i++) check("s2_stream", got[i], ref_stream[i]);

      // Start pulses during the dump are ignored
      d0 = done_cnt;
      got.delete();
      tick(); a_start = 1'b1; tick(); a_start = 1'b0;
      for (int w = 0; w < 2; w++) begin
         n = 0;
         while (!(a_rd_en && a_addr == ((w == 0) ? 5'd3 : 5'd20)) && n < 400) begin
            @(negedge clk); #1; n++;
         end
         check("s3_reach_addr", n < 400, 1);
         tick(); a_start = 1'b1; tick(); a_start = 1'b0;
      end
      wait_done(d0, 2000);
      repeat (4) tick();
      check("s3_done_count", done_cnt - d0, 1);
      check("s3_bytes", got.size(), TOTAL);

      // Long stall on the first byte
      d0 = done_cnt;
      got.delete();
      ready_fix = 1'b0;
      tick(); a_start = 1'b1; tick(); a_start = 1'b0;
      n = 0;
      while (!a_valid && n < 10) begin @(negedge clk); #1; n++; end
      check("s5_first_valid", a_valid, 1);
      repeat (1000) tick();
      #3;
      check("s5_hold_valid", a_valid, 1);
      check("s5_hold_data", a_data, 8'hA5);
      check("s5_hold_busy", a_busy, 1);
      tick();
      ready_fix = 1'b1;
      wait_done(d0, 2000);
      repeat (2) tick();
      check("s5_bytes", got.size(), TOTAL);

      // Start held through DONE re-triggers after one idle cycle
      d0 = done_cnt;
      tick(); a_start = 1'b1;
      wait_done(d0, 2000);
      @(negedge clk); #1;
      check("rt_idle_busy", a_busy, 0);
      @(negedge clk); #1;
      check("rt_read_en", a_rd_en, 1);
      check("rt_read_addr", a_addr, 0);
      tick(); a_start = 1'b0;

      // Asynchronous reset while byte 2 of address 7 is on the stream
      n = 0;
      while (!(a_valid && a_addr == 5'd7 && a_data == 8'h00) && n < 200) begin
         @(negedge clk); #1; n++;
      end
      check("s4_reach_byte", n < 200, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("s4_busy", a_busy, 0);
      check("s4_done", a_done, 0);
      check("s4_rd_en", a_rd_en, 0);
      check("s4_addr", a_addr, 0);
      check("s4_tx_data", a_data, 0);
      check("s4_tx_valid", a_valid, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      run_dump(2000, lat, nd);
      check("s4_first_addr", first_rd_addr, 0);
      check("s4_done_count", nd, 1);
      check("s4_bytes", got.size(), TOTAL);
      if (got.size() > 0) check("s4_first_byte", got[0], 8'hA5);

      // Small instance
      got_b.delete();
      d0 = done_b;
      tick(); b_start = 1'b1; tick(); b_start = 1'b0;
      n = 0;
      while (done_b == d0 && n < 200) begin @(negedge clk); #1; n++; end
      check("s6_done_seen", done_b - d0, 1);
      repeat (4) tick();
      check("s6_done_count", done_b - d0, 1);
      check("s6_reads", rd_b, 4);
      check("s6_max_addr", max_b, 3);
      check("s6_bytes", got_b.size(), 16);
      if (got_b.size() == 16)
         for (int i = 0; i < 16; i++) check("s6_stream", got_b[i], exp_b[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
